// File: rtl/pi_gear_ctrl_5bit_pkg.sv
// Shared types for the PI loop-filter gear-shift controller.
// States, sample classes and the saturating shift helper.
package pi_gear_ctrl_5bit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_TRACK  = 2'd1,
      ST_LOCKED = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      CLS_IN   = 2'd0,
      CLS_OUT  = 2'd1,
      CLS_BAND = 2'd2
   } cls_e;

   localparam int CNT_W = 5;

   function automatic logic [4:0] sat_shift(
      input logic [4:0] base,
      input logic [1:0] g
   );
      logic [5:0] s;
      s = {1'b0, base} + {4'b0000, g};
      return (s > 6'd31) ? 5'd31 : s[4:0];
   endfunction

   function automatic cls_e classify(
      input logic [4:0] e,
      input logic [4:0] lo,
      input logic [4:0] hi
   );
      if (e <= lo)
         return CLS_IN;
      else if (e > hi)
         return CLS_OUT;
      else
         return CLS_BAND;
   endfunction

endpackage

// File: rtl/pi_gear_ctrl_5bit_if.sv
// Bundle between the gear controller and its loop (samples in,
// filter shift amounts and lock status out).
interface pi_gear_ctrl_5bit_if;
   logic       pll_en;
   logic       freeze;
   logic       err_valid;
   logic       error_sign;
   logic [4:0] error;
   logic [4:0] alpha_var;
   logic [4:0] beta_var;
   logic [1:0] gear;
   logic       locked;
   logic       gear_change;

   modport master (
      output pll_en, freeze, err_valid, error_sign, error,
      input  alpha_var, beta_var, gear, locked, gear_change
   );

   modport slave (
      input  pll_en, freeze, err_valid, error_sign, error,
      output alpha_var, beta_var, gear, locked, gear_change
   );
endinterface

// File: rtl/pi_gear_ctrl_5bit_sat_run_counter.sv
// Saturating run-length counter of consecutive qualifying events.
// hit flags that one more inc would reach the target.
module sat_run_counter
   import pi_gear_ctrl_5bit_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   input  logic [CNT_W-1:0] target,
   output logic [CNT_W-1:0] cnt,
   output logic             hit
);

   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc && cnt != target)
         cnt <= cnt + 5'd1;
   end

   assign hit = (cnt == target - 5'd1);

endmodule

// File: rtl/pi_gear_ctrl_5bit.sv
// Gain-scheduling controller: steps the PI filter shift amounts
// from acquisition to tracking gears and falls back on unlock.
module pi_gear_ctrl_5bit
   import pi_gear_ctrl_5bit_pkg::*;
#(
   parameter int NUM_GEARS  = 4,
   parameter int ALPHA0     = 1,
   parameter int BETA0      = 0,
   parameter int LOCK_THR   = 2,
   parameter int UNLOCK_THR = 8,
   parameter int LOCK_CNT   = 16,
   parameter int UNLOCK_CNT = 4
) (
   input logic clk,
   input logic reset,
   pi_gear_ctrl_5bit_if.slave bus
);

   localparam logic [4:0] A0   = ALPHA0[4:0];
   localparam logic [4:0] B0   = BETA0[4:0];
   localparam logic [4:0] LTHR = LOCK_THR[4:0];
   localparam logic [4:0] UTHR = UNLOCK_THR[4:0];
   localparam logic [4:0] LCNT = LOCK_CNT[4:0];
   localparam logic [4:0] UCNT = UNLOCK_CNT[4:0];
   localparam logic [1:0] LAST = 2'(NUM_GEARS - 1);

   state_e     state_q, state_d;
   logic [1:0] gear_q, gear_d;
   logic [4:0] alpha_q, beta_q;
   logic       locked_q, gc_q;
   logic       lk_inc, lk_clr, lk_hit;
   logic       ul_inc, ul_clr, ul_hit;
   logic [4:0] lk_cnt, ul_cnt;
   cls_e       cls;

   assign cls = classify(bus.error, LTHR, UTHR);

   sat_run_counter u_lock_cnt (
      .clk    (clk),
      .reset  (reset),
      .inc    (lk_inc),
      .clr    (lk_clr),
      .target (LCNT),
      .cnt    (lk_cnt),
      .hit    (lk_hit)
   );

   sat_run_counter u_unlock_cnt (
      .clk    (clk),
      .reset  (reset),
      .inc    (ul_inc),
      .clr    (ul_clr),
      .target (UCNT),
      .cnt    (ul_cnt),
      .hit    (ul_hit)
   );

   always_comb begin
      state_d = state_q;
      gear_d  = gear_q;
      lk_inc  = 1'b0;
      lk_clr  = 1'b0;
      ul_inc  = 1'b0;
      ul_clr  = 1'b0;
      if (!bus.pll_en) begin
         state_d = ST_IDLE;
         gear_d  = '0;
         lk_clr  = 1'b1;
         ul_clr  = 1'b1;
      end else if (bus.freeze) begin
         state_d = state_q;
      end else if (state_q == ST_IDLE) begin
         state_d = ST_TRACK;
      end else if (bus.err_valid) begin
         case (cls)
            CLS_IN: begin
               lk_inc = 1'b1;
               ul_clr = 1'b1;
               // LOCKED keeps counting in-lock runs but never advances
               if (lk_hit && state_q == ST_TRACK) begin
                  gear_d = gear_q + 2'd1;
                  lk_clr = 1'b1;
                  if (gear_d == LAST)
                     state_d = ST_LOCKED;
               end
            end
            CLS_OUT: begin
               ul_inc = 1'b1;
               lk_clr = 1'b1;
               if (ul_hit) begin
                  gear_d  = '0;
                  ul_clr  = 1'b1;
                  state_d = ST_TRACK;
               end
            end
            default: begin
               lk_clr = 1'b1;
               ul_clr = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         gear_q   <= '0;
         alpha_q  <= A0;
         beta_q   <= B0;
         locked_q <= 1'b0;
         gc_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         gear_q   <= gear_d;
         alpha_q  <= sat_shift(A0, gear_d);
         beta_q   <= sat_shift(B0, gear_d);
         locked_q <= (state_d == ST_LOCKED);
         gc_q     <= (gear_d != gear_q);
      end
   end

   assign bus.alpha_var   = alpha_q;
   assign bus.beta_var    = beta_q;
   assign bus.gear        = gear_q;
   assign bus.locked      = locked_q;
   assign bus.gear_change = gc_q;

endmodule
